mem_stage_lsu: RTL

//  Load/store unit at the consuming end of the EX/MEM pipeline register. It takes the

---
 rtl/pl_mem_pkg.sv | 27 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/mem_stage_lsu.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pl_mem_pkg.sv
// rtl/pl_mem_pkg.sv - shared encodings for the MEM-stage load/store unit
package pl_mem_pkg;

    localparam logic [2:0] DM_WORD   = 3'd0;
    localparam logic [2:0] DM_HALF   = 3'd1;
    localparam logic [2:0] DM_HALF_U = 3'd2;
    localparam logic [2:0] DM_BYTE   = 3'd3;
    localparam logic [2:0] DM_BYTE_U = 3'd4;

    localparam logic [2:0] WDSEL_FROM_MEM = 3'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    // Bytes never misalign; unknown size codes are treated as full words.
    function automatic logic is_misaligned(input logic [2:0] dm, input logic [1:0] lo);
        case (dm)
            DM_BYTE, DM_BYTE_U: is_misaligned = 1'b0;
            DM_HALF, DM_HALF_U: is_misaligned = lo[0];
            default:            is_misaligned = |lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store lane replication, misalign detect, load extension
module lsu_align
    import pl_mem_pkg::*;
(
    input  logic [2:0]  st_dm_type,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    input  logic [2:0]  ld_dm_type,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] ld_data
);

    logic [31:0] sh;

    always_comb begin
        be    = 4'b1111;
        wdata = st_wdata;
        case (st_dm_type)
            DM_BYTE, DM_BYTE_U: begin
                be    = 4'b0001 << st_addr_lo;
                wdata = {4{st_wdata[7:0]}};
            end
            DM_HALF, DM_HALF_U: begin
                be    = 4'b0011 << {st_addr_lo[1], 1'b0};
                wdata = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign misalign = is_misaligned(st_dm_type, st_addr_lo);

    // Shift the addressed byte/half down to lane 0 before extending.
    always_comb begin
        sh      = ld_rdata >> {ld_addr_lo, 3'b000};
        ld_data = sh;
        case (ld_dm_type)
            DM_BYTE:   ld_data = {{24{sh[7]}}, sh[7:0]};
            DM_BYTE_U: ld_data = {24'd0, sh[7:0]};
            DM_HALF:   ld_data = {{16{sh[15]}}, sh[15:0]};
            DM_HALF_U: ld_data = {16'd0, sh[15:0]};
            default:   ld_data = sh;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit driving a req/ack data bus
module mem_stage_lsu
    import pl_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_write_in,
    input  logic        mem_read_in,
    input  logic [2:0]  dm_type_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        stall_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    lsu_state_e state;
    logic [CNT_W-1:0] cnt;
    logic        is_load_q;
    logic [2:0]  dm_q;
    logic [1:0]  addr_lo_q;

    logic        acc;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        misalign_c;
    logic [31:0] ld_ext;

    assign acc = valid_in & (mem_write_in | mem_read_in);

    lsu_align u_align (
        .st_dm_type (dm_type_in),
        .st_addr_lo (addr_in[1:0]),
        .st_wdata   (wdata_in),
        .ld_dm_type (dm_q),
        .ld_addr_lo (addr_lo_q),
        .ld_rdata   (dbus_rdata_i),
        .be         (be_c),
        .wdata      (wdata_c),
        .misalign   (misalign_c),
        .ld_data    (ld_ext)
    );

    // Stall is combinational so the accept cycle already freezes the front of the pipe.
    always_comb begin
        stall_o = 1'b0;
        if (rst) begin
            stall_o = (state == S_BUSY) || ((state == S_IDLE) && acc && !misalign_c);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            is_load_q    <= 1'b0;
            dm_q         <= 3'd0;
            addr_lo_q    <= 2'd0;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= 32'd0;
            dbus_be_o    <= 4'd0;
            dbus_wdata_o <= 32'd0;
            load_data_o  <= 32'd0;
            load_valid_o <= 1'b0;
            misalign_o   <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            load_valid_o <= 1'b0;
            misalign_o   <= 1'b0;
            timeout_o    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acc) begin
                        if (misalign_c) begin
                            misalign_o <= 1'b1;
                        end else begin
                            // A request with both read and write set is a store.
                            is_load_q    <= mem_read_in & ~mem_write_in;
                            dm_q         <= dm_type_in;
                            addr_lo_q    <= addr_in[1:0];
                            dbus_req_o   <= 1'b1;
                            dbus_we_o    <= mem_write_in;
                            dbus_addr_o  <= {addr_in[31:2], 2'b00};
                            dbus_be_o    <= be_c;
                            dbus_wdata_o <= wdata_c;
                            cnt          <= '0;
                            state        <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (dbus_ack_i) begin
                        dbus_req_o   <= 1'b0;
                        load_valid_o <= is_load_q;
                        if (is_load_q) begin
                            load_data_o <= ld_ext;
                        end
                        state <= S_DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        dbus_req_o   <= 1'b0;
                        timeout_o    <= 1'b1;
                        load_data_o  <= 32'd0;
                        load_valid_o <= is_load_q;
                        state        <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
